// File: rtl/stack_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : stack_engine_if
//  Description : Command, register-file and data-memory signals of stack_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stack_engine_if;
    logic       start;
    logic       op;
    logic [1:0] reg_idx;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic [7:0] rf_ra_data;
    logic [7:0] rf_rb_data;
    logic       rf_we;
    logic [1:0] rf_rd;
    logic [7:0] rf_wdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, op, reg_idx, rf_ra_data, rf_rb_data, mem_ack, mem_rdata,
        output rf_ra, rf_rb, rf_we, rf_rd, rf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport master (
        output start, op, reg_idx, rf_ra_data, rf_rb_data, mem_ack, mem_rdata,
        input  rf_ra, rf_rb, rf_we, rf_rd, rf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/stack_engine.sv
`default_nettype none
// ============================================================================
//  Module      : stack_engine
//  Description : PUSH/POP sequencer between a 4-entry register file (R3 = SP)
//                and a byte-wide data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_engine (
    input  wire logic         clk,
    input  wire logic         rst_n,
    stack_engine_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_MEM    = 3'd2,
        S_WB_SP  = 3'd3,
        S_WB_REG = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam logic [1:0] c_SP_REG = 2'd3;

    state_t     r_state;
    state_t     w_next;
    logic       r_op;
    logic [1:0] r_idx;
    logic [7:0] r_sp;
    logic [7:0] r_val;
    logic [7:0] r_rdata;

    logic       w_rf_we;
    logic [1:0] w_rf_rd;
    logic [7:0] w_rf_wdata;
    logic       w_mem_req;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;
    logic       w_done;
    logic       w_err;
    logic [7:0] w_sp_inc;
    logic [7:0] w_sp_dec;

    assign w_sp_inc = r_sp + 8'd1;
    assign w_sp_dec = r_sp - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            r_idx   <= 2'd0;
            r_sp    <= 8'd0;
            r_val   <= 8'd0;
            r_rdata <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op  <= bus.op;
                r_idx <= bus.reg_idx;
            end
            if (r_state == S_LATCH) begin
                r_sp  <= bus.rf_rb_data;
                r_val <= bus.rf_ra_data;
            end
            if (r_state == S_MEM && bus.mem_ack && r_op) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rf_we     = 1'b0;
        w_rf_rd     = 2'd0;
        w_rf_wdata  = 8'd0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = 8'd0;
        w_mem_wdata = 8'd0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                // Full stack (SP==0) refuses PUSH, empty stack (SP==255) refuses POP.
                if ((!r_op && bus.rf_rb_data == 8'd0) || (r_op && bus.rf_rb_data == 8'hFF)) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = r_op ? S_WB_SP : S_MEM;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_we    = ~r_op;
                w_mem_addr  = r_op ? w_sp_inc : r_sp;
                w_mem_wdata = r_op ? 8'd0 : r_val;
                if (bus.mem_ack) begin
                    w_next = r_op ? S_WB_REG : S_WB_SP;
                end
            end
            S_WB_SP: begin
                w_rf_we    = 1'b1;
                w_rf_rd    = c_SP_REG;
                w_rf_wdata = r_op ? w_sp_inc : w_sp_dec;
                w_next     = r_op ? S_MEM : S_FIN;
            end
            S_WB_REG: begin
                w_rf_we    = 1'b1;
                w_rf_rd    = r_idx;
                w_rf_wdata = r_rdata;
                w_next     = S_FIN;
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.rf_ra     = r_idx;
    assign bus.rf_rb     = c_SP_REG;
    assign bus.rf_we     = w_rf_we;
    assign bus.rf_rd     = w_rf_rd;
    assign bus.rf_wdata  = w_rf_wdata;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = w_done;
    assign bus.err       = w_err;
endmodule
`default_nettype wire

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, one-cycle command strobe; sampled only in IDLE.
REQ-004 SHALL have port op, input, 1, 0 = PUSH, 1 = POP; captured with start.
REQ-005 SHALL have port reg_idx, input, 2, register-file operand R0..R3; captured with start.
REQ-006 SHALL have port rf_ra, output, 2, register-file read address A; drives captured reg_idx.
REQ-007 SHALL have port rf_rb, output, 2, register-file read address B; constant 2'd3 (SP).
REQ-008 SHALL have port rf_ra_data, input, 8, asynchronous read data of R[rf_ra].
REQ-009 SHALL have port rf_rb_data, input, 8, asynchronous read data of R3 (SP).
REQ-010 SHALL have ports rf_we (1), rf_rd (2) and rf_wdata (8), outputs, register-file write port; a write commits on the clock edge where rf_we=1.
REQ-011 SHALL have ports mem_req (1), mem_we (1), mem_addr (8) and mem_wdata (8), outputs, data-memory request.
REQ-012 SHALL have ports mem_ack (1) and mem_rdata (8), inputs, memory completion and read data; rdata is valid in the ack cycle.
REQ-013 SHALL have outputs busy (1), done (1) and err (1): busy means a command is in progress, done is a one-cycle completion pulse, err is a one-cycle fault pulse.

Function
REQ-014 SHALL implement states IDLE, LATCH, MEM, WB_SP, WB_REG and FIN; busy=1 in every state except IDLE.
REQ-015 IDLE: start=1 SHALL capture op and reg_idx and go to LATCH; start SHALL be ignored in all other states.
REQ-016 LATCH SHALL register sp=rf_rb_data and val=rf_ra_data, one cycle.
REQ-017 PUSH fault check: in LATCH, sp==0 SHALL produce err=1 for one cycle and a return to IDLE, with no memory or register write.
REQ-018 POP fault check: in LATCH, sp==255 SHALL produce err=1 for one cycle and a return to IDLE, with no memory or register write.
REQ-019 PUSH sequence: LATCH -> MEM -> WB_SP -> FIN.
REQ-020 POP sequence: LATCH -> WB_SP -> MEM -> WB_REG -> FIN.
REQ-021 PUSH MEM: mem_req=1, mem_we=1, mem_addr=sp, mem_wdata=val, held stable until mem_ack; exit MEM in the ack cycle.
REQ-022 POP MEM: mem_req=1, mem_we=0, mem_addr=sp+1 (8-bit); in the ack cycle, mem_rdata SHALL be latched and MEM exited.
REQ-023 MEM SHALL wait for mem_ack with no bound; mem_ack outside MEM SHALL be ignored.
REQ-024 WB_SP SHALL assert for one cycle: rf_we=1, rf_rd=3, rf_wdata=sp-1 (PUSH) or sp+1 (POP).
REQ-025 WB_REG SHALL assert for one cycle: rf_we=1, rf_rd=reg_idx, rf_wdata=latched rdata.
REQ-026 POP with reg_idx=3: the WB_REG write SHALL land after WB_SP, so the final R3 equals the popped data.
REQ-027 PUSH with reg_idx=3: the stored value SHALL be the pre-decrement SP.
REQ-028 FIN SHALL pulse done=1 for one cycle and return to IDLE; a start in the cycle after FIN SHALL be accepted.
REQ-029 Outside their active states, rf_we, mem_req, mem_we, done and err SHALL be 0; rf_rd, rf_wdata, mem_addr and mem_wdata SHALL be 0 when not asserted.
REQ-030 Latency with mem_ack in the first MEM cycle SHALL be: PUSH start-to-done 4 cycles, POP start-to-done 5 cycles.

Reset
REQ-031 rst=0 SHALL force IDLE immediately, asynchronously, from any state, including mid-MEM.
REQ-032 While rst=0, every output SHALL be 0 except rf_rb=3; any pending memory transaction SHALL be abandoned (mem_req dropped).
REQ-033 After rst rises, the block SHALL accept start on the first clock edge.

Verification
REQ-034 Bench SHALL cover PUSH: SP=255, R1=0x5A, push R1, ack immediate -> mem write addr 255 data 0x5A, R3=254, done at cycle 4.
REQ-035 Bench SHALL cover POP: SP=254, M[255]=0x5A, pop R2 -> mem read addr 255, R3=255 then R2=0x5A, done at cycle 5.
REQ-036 Bench SHALL cover boundaries: push at SP=0 -> err pulse, no mem_req, R3 stays 0; pop at SP=255 -> err pulse, no writes.
REQ-037 Bench SHALL cover delayed ack: mem_ack 6 cycles late -> mem_req and address held steady, done 6 cycles later; a start during busy has no effect.
REQ-038 Bench SHALL cover reset mid-MEM: rst low -> mem_req=0 and busy=0 the same cycle; no rf_we afterwards; a new push after release works.
REQ-039 Bench SHALL cover pop into R3: SP=100, M[101]=0x33 -> rf writes R3=101 then R3=0x33.
